// File: rtl/fifo_mem_if.sv
// Handshake bundle between a producer/consumer pair and the fifo_mem buffer.
interface fifo_mem_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  trans_write;
  logic                  trans_read;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full_ind;
  logic                  empty_ind;
  logic                  threshold_ind;
  logic                  overflow_ind;
  logic                  underflow_ind;

  modport master (
    output trans_write, trans_read, data_in,
    input  data_out, full_ind, empty_ind, threshold_ind, overflow_ind, underflow_ind
  );

  modport slave (
    input  trans_write, trans_read, data_in,
    output data_out, full_ind, empty_ind, threshold_ind, overflow_ind, underflow_ind
  );
endinterface

// File: rtl/fifo_mem.sv
// Single-clock first-word-fall-through FIFO with full/empty/threshold status
// and one-cycle overflow/underflow pulses for rejected operations.
module fifo_mem #(
  parameter int DATA_WIDTH      = 16,
  parameter int OSTD_NUM        = 16,
  parameter int THRESHOLD_VALUE = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  fifo_mem_if.slave bus
);

  localparam int PTR_W = $clog2(OSTD_NUM);
  localparam int CNT_W = $clog2(OSTD_NUM + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(OSTD_NUM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(OSTD_NUM);
  localparam logic [CNT_W-1:0] THRES_CNT = CNT_W'(THRESHOLD_VALUE);

  logic [DATA_WIDTH-1:0] mem [OSTD_NUM];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic full, empty;
  logic push_ok, pop_ok;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // A pop frees a slot on the same edge, so a full FIFO can still accept a push.
  assign pop_ok  = bus.trans_read && !empty;
  assign push_ok = bus.trans_write && (!full || pop_ok);

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = bus.trans_write && !push_ok;
    underflow_next = bus.trans_read && empty;

    if (push_ok) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop_ok)  rd_ptr_next = ptr_inc(rd_ptr_reg);

    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage carries no reset; stale words are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= bus.data_in;
  end

  assign bus.data_out      = empty ? '0 : mem[rd_ptr_reg];
  assign bus.full_ind      = full;
  assign bus.empty_ind     = empty;
  assign bus.threshold_ind = (count_reg >= THRES_CNT);
  assign bus.overflow_ind  = overflow_reg;
  assign bus.underflow_ind = underflow_reg;

endmodule

// File: tb/tb_fifo_mem.sv
// Self-checking bench for fifo_mem: directed fill/drain/overflow/underflow/reset
// sequences plus randomized traffic, all scored against a queue-based model.
module tb_fifo_mem;

  localparam int DW    = 16;
  localparam int DEPTH = 18;
  localparam int THR   = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q[$];

  fifo_mem_if #(.DATA_WIDTH(DW)) bus ();

  fifo_mem #(
    .DATA_WIDTH      (DW),
    .OSTD_NUM        (DEPTH),
    .THRESHOLD_VALUE (THR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every visible output against the model occupancy/contents.
  task automatic check_status(input logic exp_ovf, input logic exp_unf);
    logic [DW-1:0] head;
    head = (q.size() == 0) ? '0 : q[0];
    check("empty_ind",     32'(bus.empty_ind),     32'(q.size() == 0));
    check("full_ind",      32'(bus.full_ind),      32'(q.size() == DEPTH));
    check("threshold_ind", 32'(bus.threshold_ind), 32'(q.size() >= THR));
    check("data_out",      32'(bus.data_out),      32'(head));
    check("overflow_ind",  32'(bus.overflow_ind),  32'(exp_ovf));
    check("underflow_ind", 32'(bus.underflow_ind), 32'(exp_unf));
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    logic pop_ok, push_ok, exp_ovf, exp_unf;
    @(negedge clk);
    bus.trans_write = w;
    bus.trans_read  = r;
    bus.data_in     = d;
    #1;
    if (r && q.size() != 0) check("head_at_read", 32'(bus.data_out), 32'(q[0]));
    pop_ok  = r && (q.size() != 0);
    push_ok = w && ((q.size() < DEPTH) || pop_ok);
    exp_ovf = w && !push_ok;
    exp_unf = r && (q.size() == 0);
    @(posedge clk);
    if (pop_ok)  q.delete(0);
    if (push_ok) q.push_back(d);
    #1;
    bus.trans_write = 1'b0;
    bus.trans_read  = 1'b0;
    check_status(exp_ovf, exp_unf);
    $display("txn w=%0b r=%0b din=%04h dout=%04h model_count=%0d ovf=%0b unf=%0b",
             w, r, d, bus.data_out, q.size(), bus.overflow_ind, bus.underflow_ind);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check_status(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset model_count=0");
  endtask

  initial begin
    bus.trans_write = 1'b0;
    bus.trans_read  = 1'b0;
    bus.data_in     = '0;

    // Power-on reset
    #12;
    check_status(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_status(1'b0, 1'b0);

    // Fill 1..17, threshold rises on the 9th, full never set
    for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, DW'(i));
    // Drain in order
    for (int i = 1; i <= 17; i++) step(1'b0, 1'b1, '0);

    // Fill to full, then a rejected write of BEEF
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(16'h100 + i));
    step(1'b1, 1'b0, 16'hBEEF);
    step(1'b0, 1'b0, '0);
    // Read+write while full: both accepted, no overflow
    step(1'b1, 1'b1, 16'h0C0D);
    step(1'b1, 1'b1, 16'h0C0E);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

    // Underflow on empty, then confirm pointers intact
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 16'h1234);
    step(1'b0, 1'b1, '0);

    // Randomized traffic in three load regimes
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic w, r;
        case (ph)
          0:       begin w = ($urandom_range(0, 99) < 75); r = ($urandom_range(0, 99) < 25); end
          1:       begin w = ($urandom_range(0, 99) < 25); r = ($urandom_range(0, 99) < 75); end
          default: begin w = $urandom_range(0, 1) == 1;    r = $urandom_range(0, 1) == 1;    end
        endcase
        step(w, r, DW'($urandom));
      end
    end

    // Drain, then mid-run reset with 5 entries held
    while (q.size() != 0) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(16'h0500 + i));
    async_reset();
    step(1'b1, 1'b0, 16'h00AA);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
